// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider.
//   DEF_DIVIDEND_W : default dividend/quotient width (matches the multiplier product width)
//   DEF_DIVISOR_W  : default divisor/remainder width (matches the multiplier operand width)
//   DEF_CNT_W      : step-counter width, enough to count DIVIDEND_W steps
//   ST_*           : FSM state encoding
package div_pkg;

    localparam int DEF_DIVIDEND_W = 6;
    localparam int DEF_DIVISOR_W  = 3;
    localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// Single restoring-division step: shift one dividend bit into the partial
// remainder, then compare against the divisor and subtract when it fits.
// Purely combinational.
// Ports:
//   p            in   DIVISOR_W+1  current partial remainder
//   dividend_bit in   1            next dividend bit (MSB first)
//   divisor      in   DIVISOR_W    divisor
//   next_p       out  DIVISOR_W+1  updated partial remainder
//   q_bit        out  1            quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   p,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   next_p,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted_s;
    logic               fits_s;

    // Shift-compare-subtract. A set top bit in p means the shifted value
    // overflows DIVISOR_W+1 bits and therefore certainly exceeds the divisor.
    always_comb begin
        shifted_s = {p[DIVISOR_W-1:0], dividend_bit};
        fits_s    = p[DIVISOR_W] | (shifted_s >= {1'b0, divisor});
        if (fits_s) begin
            next_p = shifted_s - {1'b0, divisor};
            q_bit  = 1'b1;
        end else begin
            next_p = shifted_s;
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider_6by3.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// start/busy/valid handshake. Results are held in dedicated output registers
// so the outputs only change when an operation completes or a new one starts.
// Ports:
//   clk          in   1           rising-edge clock
//   rst          in   1           asynchronous active-high reset
//   start        in   1           request, honoured only when busy=0
//   dividend     in   DIVIDEND_W  captured on an accepted start
//   divisor      in   DIVISOR_W   captured on an accepted start
//   busy         out  1           division in progress
//   valid        out  1           results valid until the next accepted start
//   quotient     out  DIVIDEND_W  result quotient
//   remainder    out  DIVISOR_W   result remainder
//   div_by_zero  out  1           captured divisor was zero
module seq_divider_6by3
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  valid,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [1:0]            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DIVIDEND_W-1:0] dividend_r;
    logic [DIVISOR_W-1:0]  divisor_r;
    logic [DIVISOR_W:0]    p_r;
    // Only the first DIVIDEND_W-1 quotient bits need storing; the last bit
    // goes straight from the step cell into the quotient output register.
    logic [DIVIDEND_W-2:0] quot_sh_r;
    logic                  busy_r;
    logic                  valid_r;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  dbz_r;

    logic [DIVISOR_W:0]    next_p_s;
    logic                  q_bit_s;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .p            (p_r),
        .dividend_bit (dividend_r[DIVIDEND_W-1]),
        .divisor      (divisor_r),
        .next_p       (next_p_s),
        .q_bit        (q_bit_s)
    );

    // FSM, operand capture, shift registers, step counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            dividend_r  <= {DIVIDEND_W{1'b0}};
            divisor_r   <= {DIVISOR_W{1'b0}};
            p_r         <= {(DIVISOR_W+1){1'b0}};
            quot_sh_r   <= {(DIVIDEND_W-1){1'b0}};
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        p_r        <= {(DIVISOR_W+1){1'b0}};
                        quot_sh_r  <= {(DIVIDEND_W-1){1'b0}};
                        if (divisor == {DIVISOR_W{1'b0}}) begin
                            // Zero divisor short-circuits: result ready next cycle.
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            valid_r     <= 1'b1;
                            dbz_r       <= 1'b1;
                            quotient_r  <= {DIVIDEND_W{1'b1}};
                            remainder_r <= {DIVISOR_W{1'b0}};
                        end else begin
                            state_r <= ST_CALC;
                            busy_r  <= 1'b1;
                            valid_r <= 1'b0;
                            dbz_r   <= 1'b0;
                            cnt_r   <= CNT_W'(DIVIDEND_W - 1);
                        end
                    end
                end
                ST_CALC: begin
                    p_r        <= next_p_s;
                    dividend_r <= {dividend_r[DIVIDEND_W-2:0], 1'b0};
                    quot_sh_r  <= {quot_sh_r[DIVIDEND_W-3:0], q_bit_s};
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        valid_r     <= 1'b1;
                        quotient_r  <= {quot_sh_r, q_bit_s};
                        remainder_r <= next_p_s[DIVISOR_W-1:0];
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign valid       = valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Self-checking bench for seq_divider_6by3: directed vector table, mid-operation
// corner cases, and an exhaustive back-to-back operand sweep.
module tb_seq_divider_6by3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       valid;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] a;
        logic [2:0] b;
        logic [5:0] q;
        logic [2:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[11];

    seq_divider_6by3 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present operands with start for one rising edge, then scramble inputs.
    task automatic launch(input logic [5:0] a, input logic [2:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 6'($urandom_range(63));
        divisor  = 3'($urandom_range(7));
    endtask

    // Count rising edges until valid, bounded so a stuck DUT cannot hang the run.
    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Shift-add multiply used to cross-check quotient*divisor.
    function automatic int mul(input logic [5:0] x, input logic [2:0] y);
        int acc = 0;
        for (int i = 0; i < 3; i++)
            if (y[i]) acc += int'(x) << i;
        return acc;
    endfunction

    initial begin
        int n;
        vecs[0]  = '{6'd45, 3'd5, 6'd9,  3'd0, 1'b0};
        vecs[1]  = '{6'd62, 3'd4, 6'd15, 3'd2, 1'b0};
        vecs[2]  = '{6'd7,  3'd7, 6'd1,  3'd0, 1'b0};
        vecs[3]  = '{6'd0,  3'd3, 6'd0,  3'd0, 1'b0};
        vecs[4]  = '{6'd63, 3'd1, 6'd63, 3'd0, 1'b0};
        vecs[5]  = '{6'd37, 3'd0, 6'd63, 3'd0, 1'b1};
        vecs[6]  = '{6'd50, 3'd7, 6'd7,  3'd1, 1'b0};
        vecs[7]  = '{6'd13, 3'd6, 6'd2,  3'd1, 1'b0};
        vecs[8]  = '{6'd6,  3'd7, 6'd0,  3'd6, 1'b0};
        vecs[9]  = '{6'd63, 3'd7, 6'd9,  3'd0, 1'b0};
        vecs[10] = '{6'd32, 3'd3, 6'd10, 3'd2, 1'b0};

        rst = 1'b1; start = 1'b0; dividend = 6'd0; divisor = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset valid", valid, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: latency, busy during the op, and results.
        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d busy", i), busy, vecs[i].z ? 0 : 1);
            wait_valid(n);
            chk($sformatf("v%0d latency", i), n, vecs[i].z ? 0 : 6);
            chk($sformatf("v%0d busy_done", i), busy, 0);
            chk($sformatf("v%0d quotient", i), quotient, vecs[i].q);
            chk($sformatf("v%0d remainder", i), remainder, vecs[i].r);
            chk($sformatf("v%0d dbz", i), div_by_zero, vecs[i].z);
        end

        // Results hold stable in DONE.
        repeat (3) @(posedge clk);
        #1;
        chk("hold valid", valid, 1);
        chk("hold quotient", quotient, 10);
        chk("hold remainder", remainder, 2);

        // Start while busy is ignored and does not disturb the result.
        launch(6'd45, 3'd5);
        launch(6'd62, 3'd4);
        wait_valid(n);
        chk("ignore latency", n, 5);
        chk("ignore quotient", quotient, 9);
        chk("ignore remainder", remainder, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("ignore no restart", busy, 0);

        // Asynchronous reset mid-calculation clears everything at once.
        launch(6'd62, 3'd4);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst valid", valid, 0);
        chk("midrst quotient", quotient, 0);
        chk("midrst remainder", remainder, 0);
        chk("midrst dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        launch(6'd7, 3'd7);
        wait_valid(n);
        chk("postrst latency", n, 6);
        chk("postrst quotient", quotient, 1);
        chk("postrst remainder", remainder, 0);

        // Exhaustive sweep, each start issued right after the previous result.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 8; b++) begin
                launch(6'(a), 3'(b));
                wait_valid(n);
                if (b == 0) begin
                    chk($sformatf("sw %0d/0 latency", a), n, 0);
                    chk($sformatf("sw %0d/0 quotient", a), quotient, 63);
                    chk($sformatf("sw %0d/0 remainder", a), remainder, 0);
                    chk($sformatf("sw %0d/0 dbz", a), div_by_zero, 1);
                end else begin
                    chk($sformatf("sw %0d/%0d latency", a, b), n, 6);
                    chk($sformatf("sw %0d/%0d quotient", a, b), quotient, a / b);
                    chk($sformatf("sw %0d/%0d remainder", a, b), remainder, a % b);
                    chk($sformatf("sw %0d/%0d rem<div", a, b), (int'(remainder) < b) ? 1 : 0, 1);
                    chk($sformatf("sw %0d/%0d mul", a, b), mul(quotient, 3'(b)), a - int'(remainder));
                    chk($sformatf("sw %0d/%0d dbz", a, b), div_by_zero, 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
